nes_fetch_unit: RTL

Parametrised instruction-fetch front end for the 6502 core: prefetches bytes from memory into a byte queue and assembles variable-length instructions (1..MAX_INSTR_SIZE bytes) for the decoder. It supersedes the two-state opcode fetch with a three-state assembler, a configurable prefetch queue and a PC redirect/flush path. It sits between the memory port and the decode stage.

---
 rtl/nes_fetch_unit.sv | 111 +++++++++++
 1 files changed

// File: rtl/nes_fetch_unit.sv
// nes_fetch_unit: byte prefetch queue and variable-length instruction assembler (NES_FETCH_BYPASS_EN adds empty-queue bypass)
module nes_fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int MAX_INSTR_SIZE = 3,
  parameter int QUEUE_DEPTH = 4,
  parameter logic [ADDR_W-1:0] BOOT_ADDR = '0,
  parameter int LEN_W = $clog2(MAX_INSTR_SIZE + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        mem_req,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic                        mem_ack,
  input  logic [7:0]                  mem_rdata,
  output logic [7:0]                  len_opcode,
  input  logic [LEN_W-1:0]            len_bytes,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  output logic [8*MAX_INSTR_SIZE-1:0] instr_bytes,
  output logic [LEN_W-1:0]            instr_len,
  output logic [ADDR_W-1:0]           instr_pc,
  input  logic                        redirect_valid,
  input  logic [ADDR_W-1:0]           redirect_pc,
  output logic [1:0]                  fetch_state
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {FETCH_OPCODE, FETCH_OPERANDS, FETCH_VALID} state_t;
  state_t state, state_n;
  logic [7:0] q [QUEUE_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic pend, stale, good, bypass, take, push, pop;
  logic [ADDR_W-1:0] pend_addr, fetch_pc, pop_pc;
  logic [LEN_W-1:0] len, held, len_lat;
  logic [7:0] cur_byte;
  assign mem_req = !rst && (pend || count < CW'(QUEUE_DEPTH));
  assign mem_addr = pend ? pend_addr : fetch_pc;
  assign good = mem_req && mem_ack && !stale && !redirect_valid;
`ifdef NES_FETCH_BYPASS_EN
  assign bypass = good && count == '0 && state != FETCH_VALID;
`else
  assign bypass = 1'b0;
`endif
  assign cur_byte = count != '0 ? q[rd_ptr] : mem_rdata;
  assign take = (count != '0 || bypass) && state != FETCH_VALID && !redirect_valid;
  assign pop = take && count != '0;
  assign push = good && !bypass;
  assign len_opcode = cur_byte;
  assign len_lat = (len_bytes == '0 || {1'b0, len_bytes} > (LEN_W + 1)'(MAX_INSTR_SIZE)) ? LEN_W'(1) : len_bytes;
  assign instr_valid = state == FETCH_VALID;
  assign instr_len = len;
  assign fetch_state = state;
  always_comb begin
    state_n = redirect_valid ? FETCH_OPCODE :
              state == FETCH_VALID ? (instr_ready ? FETCH_OPCODE : FETCH_VALID) :
              !take ? state :
              state == FETCH_OPCODE ? (len_lat == LEN_W'(1) ? FETCH_VALID : FETCH_OPERANDS) :
              held + LEN_W'(1) == len ? FETCH_VALID : FETCH_OPERANDS;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH_OPCODE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      pend <= 1'b0;
      stale <= 1'b0;
      pend_addr <= BOOT_ADDR;
      fetch_pc <= BOOT_ADDR;
      pop_pc <= BOOT_ADDR;
      len <= '0;
      held <= '0;
      instr_bytes <= '0;
      instr_pc <= BOOT_ADDR;
    end else begin
      state <= state_n;
      if (mem_req && mem_ack) begin
        pend <= 1'b0;
        stale <= 1'b0;
      end else if (mem_req) begin
        pend <= 1'b1;
        pend_addr <= mem_addr;
        stale <= stale || redirect_valid;
      end
      fetch_pc <= redirect_valid ? redirect_pc : good ? mem_addr + ADDR_W'(1) : fetch_pc;
      pop_pc <= redirect_valid ? redirect_pc : take ? pop_pc + ADDR_W'(1) : pop_pc;
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count <= '0;
      end else begin
        if (push) begin
          q[wr_ptr] <= mem_rdata;
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
      if (take && state == FETCH_OPCODE) begin
        instr_bytes <= (8 * MAX_INSTR_SIZE)'(cur_byte);
        instr_pc <= pop_pc;
        len <= len_lat;
        held <= LEN_W'(1);
      end else if (take) begin
        instr_bytes[8*held +: 8] <= cur_byte;
        held <= held + LEN_W'(1);
      end
    end
  end
endmodule
